ev2_phy_router: RTL and testbench



---
 rtl/ev2_phy_router_pkg.sv | 17 +
 rtl/ev2_sink_mux.sv | 39 +++
 rtl/ev2_phy_router.sv | 145 ++++++++++++++
 tb/tb_ev2_phy_router.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ev2_phy_router_pkg.sv
// rtl/ev2_phy_router_pkg.sv - shared types and constants for the PHY event router
package ev2_phy_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_FRM = 1;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

endpackage

// File: rtl/ev2_sink_mux.sv
// rtl/ev2_sink_mux.sv - per-sink slicing: full/count selection and write-target decode
module ev2_sink_mux #(
  parameter int NUM_SINKS   = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int SEL_WIDTH   = 2
) (
  input  logic [SEL_WIDTH-1:0]             act_sel_i,
  input  logic [SEL_WIDTH-1:0]             req_sel_i,
  input  logic [SEL_WIDTH-1:0]             fwd_sel_i,
  input  logic [NUM_SINKS-1:0]             snk_full_i,
  input  logic [NUM_SINKS*COUNT_WIDTH-1:0] snk_count_i,
  output logic                             act_full_o,
  output logic                             req_full_o,
  output logic                             req_valid_o,
  output logic [COUNT_WIDTH-1:0]           act_count_o,
  output logic [NUM_SINKS-1:0]             fwd_onehot_o
);

  // Out-of-range selectors match no sink, so they read back as not-full / zero count.
  always_comb begin
    act_full_o   = 1'b0;
    req_full_o   = 1'b0;
    req_valid_o  = 1'b0;
    act_count_o  = '0;
    fwd_onehot_o = '0;
    for (int k = 0; k < NUM_SINKS; k++) begin
      if (act_sel_i == SEL_WIDTH'(k)) begin
        act_full_o  = snk_full_i[k];
        act_count_o = snk_count_i[k*COUNT_WIDTH +: COUNT_WIDTH];
      end
      if (req_sel_i == SEL_WIDTH'(k)) begin
        req_full_o  = snk_full_i[k];
        req_valid_o = 1'b1;
      end
      fwd_onehot_o[k] = (fwd_sel_i == SEL_WIDTH'(k));
    end
  end

endmodule

// File: rtl/ev2_phy_router.sv
// rtl/ev2_phy_router.sv - routes framed PHY event words to one of NUM_SINKS sinks
module ev2_phy_router
  import ev2_phy_router_pkg::*;
#(
  parameter int NUM_SINKS   = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [SEL_WIDTH-1:0]             sel_i,
  input  logic                             enable_i,
  input  logic [DATA_WIDTH-1:0]            src_dat_i,
  input  logic                             src_wr_i,
  input  logic                             src_sof_i,
  input  logic                             src_eof_i,
  output logic                             src_full_o,
  output logic [COUNT_WIDTH-1:0]           src_count_o,
  input  logic                             src_rst_i,
  output logic                             src_rst_ack_o,
  output logic [NUM_SINKS*DATA_WIDTH-1:0]  snk_dat_o,
  output logic [NUM_SINKS-1:0]             snk_wr_o,
  input  logic [NUM_SINKS-1:0]             snk_full_i,
  input  logic [NUM_SINKS*COUNT_WIDTH-1:0] snk_count_i,
  output logic [NUM_SINKS-1:0]             snk_rst_o,
  input  logic [NUM_SINKS-1:0]             snk_rst_ack_i,
  output logic [SEL_WIDTH-1:0]             active_sel_o,
  output logic [DROP_W-1:0]                dropped_o,
  output logic [1:0]                       err_o
);

  state_e                        state_q, state_d;
  logic [SEL_WIDTH-1:0]          sel_q, sel_d;
  logic [DROP_W-1:0]             drop_q, drop_d;
  logic [1:0]                    err_q, err_d;
  logic                          ack_q;
  logic [NUM_SINKS-1:0]          snk_wr_q;
  logic [NUM_SINKS*DATA_WIDTH-1:0] snk_dat_q;

  logic                          fwd;
  logic [SEL_WIDTH-1:0]          fwd_sel;
  logic                          act_full, req_full, req_valid;
  logic [NUM_SINKS-1:0]          fwd_onehot;

  ev2_sink_mux #(
    .NUM_SINKS  (NUM_SINKS),
    .COUNT_WIDTH(COUNT_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .act_sel_i   (sel_q),
    .req_sel_i   (sel_i),
    .fwd_sel_i   (fwd_sel),
    .snk_full_i  (snk_full_i),
    .snk_count_i (snk_count_i),
    .act_full_o  (act_full),
    .req_full_o  (req_full),
    .req_valid_o (req_valid),
    .act_count_o (src_count_o),
    .fwd_onehot_o(fwd_onehot)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = drop_q;
    err_d   = err_q;
    fwd     = 1'b0;
    fwd_sel = sel_q;
    if (src_rst_i) begin
      // An abandoned frame is neither forwarded nor counted as dropped.
      state_d = ST_RESET;
      if (state_q == ST_RESET) err_d = '0;
    end else if (state_q == ST_RESET) begin
      state_d = ST_IDLE;
      err_d   = '0;
    end else if (src_wr_i) begin
      if (src_sof_i) begin
        // SOF always opens a new frame; outside IDLE it also means the old frame lost its EOF.
        if (state_q != ST_IDLE) err_d[ERR_FRM] = 1'b1;
        if (state_q == ST_ROUTE && act_full) err_d[ERR_OVF] = 1'b1;
        sel_d = sel_i;
        if (enable_i && req_valid) begin
          fwd     = 1'b1;
          fwd_sel = sel_i;
          state_d = src_eof_i ? ST_IDLE : ST_ROUTE;
        end else begin
          if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
          state_d = src_eof_i ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_IDLE: err_d[ERR_FRM] = 1'b1;
          ST_ROUTE: begin
            fwd = 1'b1;
            if (act_full) err_d[ERR_OVF] = 1'b1;
            if (src_eof_i) state_d = ST_IDLE;
          end
          ST_DROP: if (src_eof_i) state_d = ST_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_ROUTE: src_full_o = act_full;
      ST_IDLE:  src_full_o = req_full;
      ST_DROP:  src_full_o = 1'b0;
      default:  src_full_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      drop_q    <= '0;
      err_q     <= '0;
      ack_q     <= 1'b0;
      snk_wr_q  <= '0;
      snk_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      ack_q    <= &snk_rst_ack_i;
      snk_wr_q <= fwd ? fwd_onehot : '0;
      for (int k = 0; k < NUM_SINKS; k++) begin
        if (fwd && fwd_onehot[k]) snk_dat_q[k*DATA_WIDTH +: DATA_WIDTH] <= src_dat_i;
      end
    end
  end

  assign snk_wr_o      = snk_wr_q;
  assign snk_dat_o     = snk_dat_q;
  assign snk_rst_o     = rst_i ? '0 : {NUM_SINKS{src_rst_i}};
  assign src_rst_ack_o = ack_q && (state_q == ST_RESET);
  assign active_sel_o  = sel_q;
  assign dropped_o     = drop_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ev2_phy_router.sv
// tb/tb_ev2_phy_router.sv - directed scoreboard bench for ev2_phy_router
module tb_ev2_phy_router;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  sel_i;
  logic        enable_i;
  logic [15:0] src_dat_i;
  logic        src_wr_i, src_sof_i, src_eof_i;
  logic        src_full_o;
  logic [15:0] src_count_o;
  logic        src_rst_i;
  logic        src_rst_ack_o;
  logic [31:0] snk_dat_o;
  logic [1:0]  snk_wr_o;
  logic [1:0]  snk_full_i;
  logic [31:0] snk_count_i;
  logic [1:0]  snk_rst_o;
  logic [1:0]  snk_rst_ack_i;
  logic [1:0]  active_sel_o;
  logic [15:0] dropped_o;
  logic [1:0]  err_o;

  typedef struct {
    int          sink;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  ev2_phy_router dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .enable_i(enable_i),
    .src_dat_i(src_dat_i), .src_wr_i(src_wr_i), .src_sof_i(src_sof_i), .src_eof_i(src_eof_i),
    .src_full_o(src_full_o), .src_count_o(src_count_o),
    .src_rst_i(src_rst_i), .src_rst_ack_o(src_rst_ack_o),
    .snk_dat_o(snk_dat_o), .snk_wr_o(snk_wr_o), .snk_full_i(snk_full_i),
    .snk_count_i(snk_count_i), .snk_rst_o(snk_rst_o), .snk_rst_ack_i(snk_rst_ack_i),
    .active_sel_o(active_sel_o), .dropped_o(dropped_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [15:0] d, input logic sof, input logic eof,
                    input bit exp_fwd, input int sink);
    exp_t e;
    src_dat_i = d;
    src_wr_i  = 1'b1;
    src_sof_i = sof;
    src_eof_i = eof;
    if (exp_fwd) begin
      e.sink = sink;
      e.dat  = d;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    step();
    src_wr_i  = 1'b0;
    src_sof_i = 1'b0;
    src_eof_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (mon_en && snk_wr_o !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {30'd0, snk_wr_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_strobe", {30'd0, snk_wr_o}, 32'd1 << e.sink);
        chk("write_data", {16'd0, snk_dat_o[e.sink*16 +: 16]}, {16'd0, e.dat});
        chk("write_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_i = 1'b1; sel_i = 2'd0; enable_i = 1'b1; src_dat_i = '0;
    src_wr_i = 1'b0; src_sof_i = 1'b0; src_eof_i = 1'b0; src_rst_i = 1'b0;
    snk_full_i = 2'b00; snk_count_i = {16'h0222, 16'h0111}; snk_rst_ack_i = 2'b00;
    step(); step();
    rst_i = 1'b0;
    mon_en = 1'b1;
    chk("reset_wr", {30'd0, snk_wr_o}, 32'd0);
    chk("reset_sel", {30'd0, active_sel_o}, 32'd0);
    chk("reset_dropped", {16'd0, dropped_o}, 32'd0);
    chk("reset_err", {30'd0, err_o}, 32'd0);
    chk("reset_ack", {31'd0, src_rst_ack_o}, 32'd0);
    chk("reset_snk_rst", {30'd0, snk_rst_o}, 32'd0);

    // forwarding to sink 1
    sel_i = 2'd1; enable_i = 1'b1;
    wr(16'hA000, 1, 0, 1, 1);
    wr(16'hA001, 0, 0, 1, 1);
    wr(16'hA002, 0, 0, 1, 1);
    wr(16'hA003, 0, 1, 1, 1);
    step();
    chk("fwd_drained", sb.size(), 0);
    chk("fwd_dropped", {16'd0, dropped_o}, 32'd0);
    chk("fwd_active", {30'd0, active_sel_o}, 32'd1);
    chk("fwd_count", {16'd0, src_count_o}, 32'h0222);

    // disabled frame is dropped
    sel_i = 2'd0; enable_i = 1'b0;
    wr(16'hB000, 1, 0, 0, 0);
    wr(16'hB001, 0, 0, 0, 0);
    wr(16'hB002, 0, 1, 0, 0);
    step();
    chk("drop_disabled", {16'd0, dropped_o}, 32'd1);

    // out-of-range sink is dropped
    sel_i = 2'd3; enable_i = 1'b1;
    wr(16'hC000, 1, 0, 0, 0);
    chk("drop_full_in_drop", {31'd0, src_full_o}, 32'd0);
    wr(16'hC001, 0, 1, 0, 0);
    step();
    chk("drop_range", {16'd0, dropped_o}, 32'd2);
    chk("drop_range_sel", {30'd0, active_sel_o}, 32'd3);
    chk("drop_range_count", {16'd0, src_count_o}, 32'd0);

    // sel/enable changes mid-frame are ignored
    sel_i = 2'd0; enable_i = 1'b1;
    wr(16'hD000, 1, 0, 1, 0);
    wr(16'hD001, 0, 0, 1, 0);
    sel_i = 2'd1; enable_i = 1'b0;
    wr(16'hD002, 0, 0, 1, 0);
    chk("mid_active", {30'd0, active_sel_o}, 32'd0);
    wr(16'hD003, 0, 0, 1, 0);
    wr(16'hD004, 0, 1, 1, 0);
    step();
    chk("mid_drained", sb.size(), 0);
    chk("mid_active_after", {30'd0, active_sel_o}, 32'd0);
    chk("mid_count", {16'd0, src_count_o}, 32'h0111);
    chk("mid_err", {30'd0, err_o}, 32'd0);

    // overflow: full on word 3, written anyway
    sel_i = 2'd0; enable_i = 1'b1;
    wr(16'hE000, 1, 0, 1, 0);
    wr(16'hE001, 0, 0, 1, 0);
    snk_full_i = 2'b01;
    #1;
    chk("ovf_full", {31'd0, src_full_o}, 32'd1);
    wr(16'hE002, 0, 0, 1, 0);
    snk_full_i = 2'b00;
    wr(16'hE003, 0, 1, 1, 0);
    step();
    chk("ovf_err", {30'd0, err_o}, 32'd1);
    chk("ovf_drained", sb.size(), 0);

    // reset handshake mid-frame
    sel_i = 2'd1;
    wr(16'hF000, 1, 0, 1, 1);
    wr(16'hF001, 0, 0, 1, 1);
    src_rst_i = 1'b1;
    #1;
    chk("rst_snk_rst", {30'd0, snk_rst_o}, 32'd3);
    step();
    chk("rst_full", {31'd0, src_full_o}, 32'd1);
    snk_rst_ack_i = 2'b01;
    wr(16'hF002, 0, 1, 0, 0);
    step();
    chk("rst_ack_partial", {31'd0, src_rst_ack_o}, 32'd0);
    snk_rst_ack_i = 2'b11;
    #1;
    chk("rst_ack_not_yet", {31'd0, src_rst_ack_o}, 32'd0);
    step();
    chk("rst_ack_high", {31'd0, src_rst_ack_o}, 32'd1);
    chk("rst_snk_rst_held", {30'd0, snk_rst_o}, 32'd3);
    src_rst_i = 1'b0;
    snk_rst_ack_i = 2'b00;
    step();
    chk("rst_err_cleared", {30'd0, err_o}, 32'd0);
    chk("rst_dropped_kept", {16'd0, dropped_o}, 32'd2);
    chk("rst_ack_low", {31'd0, src_rst_ack_o}, 32'd0);
    chk("rst_snk_rst_low", {30'd0, snk_rst_o}, 32'd0);
    sel_i = 2'd0;
    wr(16'h1234, 1, 1, 1, 0);
    step();
    chk("rst_idle_fwd", sb.size(), 0);

    // framing: word without SOF in IDLE, then SOF inside a routed frame
    wr(16'h5555, 0, 0, 0, 0);
    step();
    chk("frm_no_sof", {30'd0, err_o}, 32'd2);
    wr(16'h6000, 1, 1, 1, 0);
    wr(16'h6001, 1, 0, 1, 0);
    sel_i = 2'd1;
    wr(16'h6002, 1, 0, 1, 1);
    wr(16'h6003, 0, 1, 1, 1);
    step();
    chk("frm_resync_sel", {30'd0, active_sel_o}, 32'd1);
    chk("frm_err", {30'd0, err_o}, 32'd2);
    chk("frm_drained", sb.size(), 0);

    // dropped counter saturation
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("sat_start", {16'd0, dropped_o}, 32'd0);
    enable_i = 1'b0;
    for (int i = 0; i < 65535; i++) wr(16'h0000, 1, 1, 0, 0);
    chk("sat_max", {16'd0, dropped_o}, 32'hFFFF);
    wr(16'h0000, 1, 1, 0, 0);
    wr(16'h0000, 1, 1, 0, 0);
    chk("sat_hold", {16'd0, dropped_o}, 32'hFFFF);
    step();
    chk("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
